// File: rtl/clk_div_gen.sv
// Programmable integer clock divider, 50% duty for even and odd divisors.
// Divisor changes are deferred to a period boundary; tick marks each clk_out rise in the clk domain.
module clk_div_gen #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_pending,
    output logic             div_err
);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_pend_next;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] half_len;
    logic             p;
    logic             p_next;
    logic             n;
    logic             ext;
    logic             boundary;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic             pending_next;
    logic             tick_next;

    always_comb begin
        load_ok       = div_load && (div_in >= TWO);
        load_bad      = div_load && (div_in < TWO);
        boundary      = en && (cnt == div_cur - ONE);
        // A pending divisor takes over at a boundary, or at once while stopped.
        apply         = div_pending && (boundary || !en);
        div_next      = apply ? div_pend : div_cur;
        // p covers the floor(N/2) whole cycles; for odd N the negedge copy adds the last half cycle,
        // so every rise stays on a posedge and the fall lands on a negedge.
        half_len      = div_next >> 1;
        if (!en)
            cnt_next = div_next - ONE;
        else if (boundary)
            cnt_next = '0;
        else
            cnt_next = cnt + ONE;
        p_next        = en && (cnt_next < half_len);
        tick_next     = en && (cnt_next == '0);
        div_pend_next = load_ok ? div_in : div_pend;
        pending_next  = load_ok || (div_pending && !apply);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= DIV_RST - ONE;
            div_cur     <= DIV_RST;
            div_pend    <= DIV_RST;
            div_pending <= 1'b0;
            p           <= 1'b0;
            ext         <= 1'b0;
            tick        <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            div_cur     <= div_next;
            div_pend    <= div_pend_next;
            div_pending <= pending_next;
            p           <= p_next;
            // Qualifies the half-cycle tail so stop and reset drop clk_out on the posedge.
            ext         <= en && p;
            tick        <= tick_next;
            div_err     <= load_bad;
        end
    end

    always_ff @(negedge clk) begin
        n <= p;
    end

    assign clk_out = div_cur[0] ? (p | (n & ext)) : p;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: measures clk_out high time and period in half cycles
// against a queue of expected shapes pushed as each stimulus step is issued.
module tb_clk_div_gen;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] div_cur;
    logic             div_pending;
    logic             div_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    per;
        int    hi;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    clk_div_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_cur    (div_cur),
        .div_pending(div_pending),
        .div_err    (div_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(clk);
        #1;
    endtask

    task automatic push(input string tag, input int n);
        exp_t e;
        e.tag = tag;
        e.per = 2 * n;
        e.hi  = n;
        sb.push_back(e);
    endtask

    // Starts on the sample just after a clk_out rise and ends on the sample after the next rise.
    // Optional loads are driven after the posedge whose cnt index equals la1 / la2.
    task automatic measure(input int la1, input int lv1, input int la2, input int lv2);
        exp_t e;
        int   per;
        int   hi;
        int   ticks;
        int   j;
        int   last_val;
        bit   fell;
        bit   load_active;
        bit   pend_exp;
        e = sb.pop_front();
        chk({e.tag, " rise_on_posedge"}, int'(clk), 1);
        chk({e.tag, " tick_at_rise"}, int'(tick), 1);
        per = 0; hi = 0; ticks = 0; j = 0; last_val = 0;
        fell = 1'b0; load_active = 1'b0; pend_exp = 1'b0;
        if (la1 == 0) begin
            div_in = lv1[WIDTH-1:0]; div_load = 1'b1; load_active = 1'b1; last_val = lv1;
        end
        while (per < 1200) begin
            half();
            per++;
            if (clk && load_active) begin
                if (last_val >= 2) begin
                    pend_exp = 1'b1;
                    chk({e.tag, " load_pending"}, int'(div_pending), 1);
                    chk({e.tag, " load_no_err"}, int'(div_err), 0);
                end else begin
                    chk({e.tag, " reject_err"}, int'(div_err), 1);
                    chk({e.tag, " reject_pending"}, int'(div_pending), int'(pend_exp));
                end
                div_load = 1'b0;
                load_active = 1'b0;
            end
            if (!fell && !clk_out) begin
                fell = 1'b1;
                hi = per;
            end else if (fell && clk_out) begin
                break;
            end
            if (clk) begin
                if (tick) ticks++;
                j++;
                if (j == la1) begin
                    div_in = lv1[WIDTH-1:0]; div_load = 1'b1; load_active = 1'b1; last_val = lv1;
                end else if (j == la2) begin
                    div_in = lv2[WIDTH-1:0]; div_load = 1'b1; load_active = 1'b1; last_val = lv2;
                end
            end
        end
        chk({e.tag, " high_halves"}, hi, e.hi);
        chk({e.tag, " period_halves"}, per, e.per);
        chk({e.tag, " stray_ticks"}, ticks, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
        repeat (3) cyc();
        chk("rst clk_out", int'(clk_out), 0);
        chk("rst tick", int'(tick), 0);
        chk("rst div_cur", int'(div_cur), 10);
        chk("rst div_pending", int'(div_pending), 0);
        chk("rst div_err", int'(div_err), 0);

        rst_n = 1'b1; en = 1'b1;
        cyc();
        chk("start tick", int'(tick), 1);
        chk("start clk_out", int'(clk_out), 1);
        chk("start div_cur", int'(div_cur), 10);
        push("n10_a", 10); measure(-1, 0, -1, 0);
        push("n10_b", 10); measure(-1, 0, -1, 0);

        push("n10_load7", 10); measure(3, 7, -1, 0);
        chk("after7 div_cur", int'(div_cur), 7);
        chk("after7 div_pending", int'(div_pending), 0);
        push("n7_a", 7); measure(-1, 0, -1, 0);
        push("n7_b", 7); measure(-1, 0, -1, 0);

        push("n7_load3_2", 7); measure(1, 3, 2, 2);
        chk("after32 div_cur", int'(div_cur), 2);
        chk("after32 div_pending", int'(div_pending), 0);
        push("n2_a", 2); measure(-1, 0, -1, 0);
        push("n2_b", 2); measure(-1, 0, -1, 0);

        push("n2_load3", 2); measure(0, 3, -1, 0);
        chk("after3 div_cur", int'(div_cur), 3);
        push("n3_a", 3); measure(-1, 0, -1, 0);
        push("n3_err", 3); measure(0, 1, 1, 0);
        chk("err div_cur", int'(div_cur), 3);
        chk("err div_pending", int'(div_pending), 0);
        push("n3_b", 3); measure(-1, 0, -1, 0);
        chk("err cleared", int'(div_err), 0);

        en = 1'b0;
        cyc();
        chk("stop clk_out", int'(clk_out), 0);
        chk("stop tick", int'(tick), 0);
        div_in = 8'd5; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        chk("idle load pending", int'(div_pending), 1);
        chk("idle load div_cur", int'(div_cur), 3);
        cyc();
        chk("idle apply div_cur", int'(div_cur), 5);
        chk("idle apply pending", int'(div_pending), 0);
        en = 1'b1;
        cyc();
        chk("n5 start tick", int'(tick), 1);
        chk("n5 start clk_out", int'(clk_out), 1);
        push("n5_a", 5); measure(-1, 0, -1, 0);
        push("n5_b", 5); measure(-1, 0, -1, 0);

        rst_n = 1'b0;
        cyc();
        chk("midrst clk_out", int'(clk_out), 0);
        chk("midrst div_cur", int'(div_cur), 10);
        chk("midrst tick", int'(tick), 0);
        chk("midrst pending", int'(div_pending), 0);
        rst_n = 1'b1;
        cyc();
        chk("postrst tick", int'(tick), 1);
        chk("postrst clk_out", int'(clk_out), 1);
        push("n10_postrst", 10); measure(-1, 0, -1, 0);

        repeat (3) cyc();
        chk("midhigh clk_out", int'(clk_out), 1);
        en = 1'b0;
        cyc();
        chk("toggle stop clk_out", int'(clk_out), 0);
        chk("toggle stop tick", int'(tick), 0);
        en = 1'b1;
        cyc();
        chk("reen tick", int'(tick), 1);
        chk("reen clk_out", int'(clk_out), 1);
        push("n10_reen", 10); measure(-1, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
